ncl_mult3_arbiter: RTL and testbench
====================================

Name: ncl_mult3_arbiter

Overview:
Synchronous front-end that shares one 3x3 NCL dual-rail multiplier among NREQ clocked requesters. It arbitrates requests round-robin and encodes the granted 3-bit operands to dual-rail. It sequences the four-phase DATA/NULL wavefront via the multiplier's Ki/Ko handshake. It detects output completion through synchronizers and returns the decoded 6-bit product to the winning requester. It sits between the clocked control domain and the asynchronous NCL multiplier macro.

Parameters:
NREQ, 4, number of requesters (2..8); ID width = clog2(NREQ).
SYNC_STAGES, 2, flop stages on every async input (mul_ko, all product rails).
TIMEOUT, 64, max cycles allowed in DATA or NULL wait before error.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
req_valid  in  NREQ  per-requester request
req_a  in  3*NREQ  operand A, requester i at [3i+2:3i]
req_b  in  3*NREQ  operand B, same packing
req_ready  out  NREQ  one-cycle grant/accept pulse; operands latched that cycle
rsp_valid  out  1  product available
rsp_id  out  clog2(NREQ)  requester index of product
rsp_p  out  6  unsigned product A*B
rsp_ready  in  1  consumer accepts product when rsp_valid&rsp_ready
mul_a_r1, mul_a_r0  out  3  dual-rail A to multiplier
mul_b_r1, mul_b_r0  out  3  dual-rail B to multiplier
mul_ki  out  1  request to multiplier: 1 = request DATA, 0 = request NULL
mul_p_r1, mul_p_r0  in  6  dual-rail product from multiplier (async)
mul_ko  in  1  multiplier acknowledge (async; 1 = ready for DATA)
err_timeout  out  1  sticky, set on handshake timeout
err_illegal  out  1  sticky, set when any product bit has both rails high
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, rr pointer=0, all mul_*_r1/r0=0 (NULL), mul_ki=1, req_ready=0, rsp_valid=0, rsp_id=0, rsp_p=0, err_*=0, busy=0, synchronizer flops=0, timeout counter=0. Reset mid-operation abandons the transaction. The pending result is discarded. The multiplier is driven NULL immediately.
- All decisions use only synchronized copies: ko_s, p_r1_s, p_r0_s. Rails are monotonic within a phase, so per-bit synchronization is safe.
- Completion definitions:
  - all_data = every bit has exactly one rail high.
  - all_null = all 12 rails low.
  - illegal = any bit has both rails high.
- IDLE: inputs NULL, mul_ki=1. Grant when all of the following hold:
  - some req_valid is high;
  - rsp_valid=0 (single result buffer);
  - ko_s=1.
  Winner is the first valid index scanning from rr pointer upward, wrapping. In the grant cycle: req_ready[winner]=1 for exactly one cycle, operands and id latched, rr pointer = winner+1 mod NREQ, then go to DATA.
- DATA: drive latched operands dual-rail (r1=bit, r0=~bit), mul_ki=1. Exit conditions:
  - all_data & ~illegal: capture decoded product (rsp_p = p_r1_s), set rsp_valid and rsp_id next cycle, go to NULLW.
  - illegal seen: set err_illegal, discard result, go to NULLW.
- NULLW: inputs NULL, mul_ki=0. When all_null & ko_s=1: mul_ki=1, go to IDLE.
- Timeout: the counter clears on every state entry and increments in DATA and NULLW.
  - Reaching TIMEOUT in DATA: set err_timeout, discard result, go to NULLW.
  - Reaching TIMEOUT in NULLW: set err_timeout, go to HALT.
  - HALT: inputs NULL, mul_ki=0, no grants. Exit only by rst.
- Response: rsp_valid holds with stable rsp_id/rsp_p until rsp_ready. It clears the cycle after the handshake. A new grant may occur in the same cycle the response is accepted only if rsp_valid is already low; no bypass.
- Simultaneous req_valid from all requesters: strict round-robin; each is served once per NREQ grants.
- req_valid dropping before grant: no effect, no pulse.
- Minimum transaction latency, grant to rsp_valid: 1 + SYNC_STAGES + multiplier delay cycles.

Test Plan:
- Req0 A=7,B=7, behavioural NCL model → req_ready[0] pulse. Rails: a_r1=111, a_r0=000, b_r1=111, b_r0=000. Product: rsp_p=6'b110001 (49), rsp_id=0. mul_ki returns 1 only after NULL observed.
- Req2 A=0,B=5 → rsp_p=0. During DATA: mul_a_r0=111, mul_b_r1=101.
- req_valid=4'b1111 held, rsp_ready=1 → grants in order 0,1,2,3,0. Each grant is a single-cycle pulse.
- rsp_ready=0 for 20 cycles after first result, req1 pending → no second grant, rsp_p stable. Grant issues after rsp_ready is asserted.
- Model never asserts product rails → after TIMEOUT=64 cycles err_timeout=1, no rsp_valid, state NULLW. Model stuck non-NULL → HALT, mul_ki=0 until rst.
- rst asserted mid-DATA → next cycle all mul rails 0, mul_ki=1, rsp_valid=0, errors clear. Fresh request 3*2 → rsp_p=6.

Source files
------------

// File: rtl/ncl_mult3_arbiter.sv
// Clocked round-robin front-end that shares one 3x3 NCL dual-rail multiplier among NREQ requesters.
// Sequences DATA/NULL wavefronts over Ki/Ko using synchronized completion detection of the product rails.

module ncl_mult3_arbiter #(
  parameter int  NREQ        = 4,
  parameter int  SYNC_STAGES = 2,
  parameter int  TIMEOUT     = 64,
  localparam int IDW         = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_a,
  input  logic [3*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [5:0]        rsp_p,
  input  logic              rsp_ready,
  output logic [2:0]        mul_a_r1,
  output logic [2:0]        mul_a_r0,
  output logic [2:0]        mul_b_r1,
  output logic [2:0]        mul_b_r0,
  output logic              mul_ki,
  input  logic [5:0]        mul_p_r1,
  input  logic [5:0]        mul_p_r0,
  input  logic              mul_ko,
  output logic              err_timeout,
  output logic              err_illegal,
  output logic              busy
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_NULLW = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  function automatic logic f_all_data(input logic [5:0] r1, input logic [5:0] r0);
    return &(r1 ^ r0);
  endfunction

  function automatic logic f_all_null(input logic [5:0] r1, input logic [5:0] r0);
    return ~|(r1 | r0);
  endfunction

  function automatic logic f_illegal(input logic [5:0] r1, input logic [5:0] r0);
    return |(r1 & r0);
  endfunction

  state_t                 r_state;
  logic [IDW-1:0]         r_ptr;
  logic [IDW-1:0]         r_id;
  logic [CW-1:0]          r_cnt;
  logic [NREQ-1:0]        r_req_ready;
  logic                   r_rsp_valid;
  logic [IDW-1:0]         r_rsp_id;
  logic [5:0]             r_rsp_p;
  logic [11:0]            r_in;
  logic                   r_ki;
  logic                   r_err_timeout;
  logic                   r_err_illegal;
  logic                   r_busy;

  logic [SYNC_STAGES-1:0] r_ko_sync;
  logic [5:0]             r_p1_sync [SYNC_STAGES];
  logic [5:0]             r_p0_sync [SYNC_STAGES];

  logic                   w_ko_s;
  logic [5:0]             w_p1_s;
  logic [5:0]             w_p0_s;
  logic                   w_all_data;
  logic                   w_all_null;
  logic                   w_illegal;
  logic                   w_found;
  logic [IDW-1:0]         w_win;
  logic [IDW:0]           w_scan;
  logic [IDW-1:0]         w_ptr_nxt;
  logic [2:0]             w_op_a;
  logic [2:0]             w_op_b;

  // Per-bit synchronizers on every asynchronous multiplier output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ko_sync <= {SYNC_STAGES{1'b0}};
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_p1_sync[i] <= 6'd0;
        r_p0_sync[i] <= 6'd0;
      end
    end else begin
      r_ko_sync[0] <= mul_ko;
      r_p1_sync[0] <= mul_p_r1;
      r_p0_sync[0] <= mul_p_r0;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_ko_sync[i] <= r_ko_sync[i-1];
        r_p1_sync[i] <= r_p1_sync[i-1];
        r_p0_sync[i] <= r_p0_sync[i-1];
      end
    end
  end

  assign w_ko_s     = r_ko_sync[SYNC_STAGES-1];
  assign w_p1_s     = r_p1_sync[SYNC_STAGES-1];
  assign w_p0_s     = r_p0_sync[SYNC_STAGES-1];
  assign w_all_data = f_all_data(w_p1_s, w_p0_s);
  assign w_all_null = f_all_null(w_p1_s, w_p0_s);
  assign w_illegal  = f_illegal(w_p1_s, w_p0_s);

  // Round-robin winner: first valid index at or above the pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_scan  = {(IDW+1){1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      w_scan = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_scan >= (IDW+1)'(NREQ)) begin
        w_scan = w_scan - (IDW+1)'(NREQ);
      end else begin
        w_scan = w_scan;
      end
      if (!w_found && req_valid[w_scan[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_scan[IDW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Pointer advance past the winner
  always_comb begin
    if (w_win == IDW'(NREQ - 1)) begin
      w_ptr_nxt = {IDW{1'b0}};
    end else begin
      w_ptr_nxt = w_win + IDW'(1);
    end
  end

  assign w_op_a = req_a[3*w_win +: 3];
  assign w_op_b = req_b[3*w_win +: 3];

  // Transaction sequencer: grant, DATA wavefront, NULL wavefront, timeout/halt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= {IDW{1'b0}};
      r_id          <= {IDW{1'b0}};
      r_cnt         <= {CW{1'b0}};
      r_req_ready   <= {NREQ{1'b0}};
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= {IDW{1'b0}};
      r_rsp_p       <= 6'd0;
      r_in          <= 12'd0;
      r_ki          <= 1'b1;
      r_err_timeout <= 1'b0;
      r_err_illegal <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_req_ready <= {NREQ{1'b0}};
      if (w_illegal) begin
        r_err_illegal <= 1'b1;
      end else begin
        r_err_illegal <= r_err_illegal;
      end
      if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end else begin
        r_rsp_valid <= r_rsp_valid;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= {CW{1'b0}};
          r_ki  <= 1'b1;
          if (w_found && !r_rsp_valid && w_ko_s) begin
            r_req_ready[w_win] <= 1'b1;
            r_id    <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_in    <= {w_op_a, ~w_op_a, w_op_b, ~w_op_b};
            r_busy  <= 1'b1;
            r_state <= S_DATA;
          end else begin
            r_in   <= 12'd0;
            r_busy <= 1'b0;
          end
        end
        S_DATA: begin
          // Illegal rails win over completion; a bad result is never delivered
          if (w_illegal) begin
            r_in    <= 12'd0;
            r_ki    <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_state <= S_NULLW;
          end else if (w_all_data) begin
            r_rsp_p     <= w_p1_s;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_in        <= 12'd0;
            r_ki        <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_state     <= S_NULLW;
          end else if (r_cnt == CNT_LAST) begin
            r_err_timeout <= 1'b1;
            r_in          <= 12'd0;
            r_ki          <= 1'b0;
            r_cnt         <= {CW{1'b0}};
            r_state       <= S_NULLW;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_NULLW: begin
          r_in <= 12'd0;
          if (w_all_null && w_ko_s) begin
            r_ki    <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_err_timeout <= 1'b1;
            r_ki          <= 1'b0;
            r_cnt         <= {CW{1'b0}};
            r_state       <= S_HALT;
          end else begin
            r_ki  <= 1'b0;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HALT: begin
          r_in   <= 12'd0;
          r_ki   <= 1'b0;
          r_busy <= 1'b1;
          r_cnt  <= {CW{1'b0}};
        end
        default: begin
          r_in    <= 12'd0;
          r_ki    <= 1'b0;
          r_busy  <= 1'b1;
          r_cnt   <= {CW{1'b0}};
          r_state <= S_NULLW;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_p       = r_rsp_p;
  assign mul_a_r1    = r_in[11:9];
  assign mul_a_r0    = r_in[8:6];
  assign mul_b_r1    = r_in[5:3];
  assign mul_b_r0    = r_in[2:0];
  assign mul_ki      = r_ki;
  assign err_timeout = r_err_timeout;
  assign err_illegal = r_err_illegal;
  assign busy        = r_busy;

endmodule

// File: tb/tb_ncl_mult3_arbiter.sv
// Randomized bench for ncl_mult3_arbiter: behavioural NCL multiplier, round-robin/scoreboard
// reference model, and directed scenarios for hold-off, timeout, halt, illegal rails and reset.

module tb_ncl_mult3_arbiter;

  localparam int NREQ        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 64;
  localparam int IDW         = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [5:0]        rsp_p;
  logic              rsp_ready;
  logic [2:0]        mul_a_r1, mul_a_r0, mul_b_r1, mul_b_r0;
  logic              mul_ki;
  logic [5:0]        mul_p_r1, mul_p_r0;
  logic              mul_ko;
  logic              err_timeout, err_illegal, busy;

  int n_checks = 0;
  int n_errors = 0;

  // multiplier model mode: 0 normal, 1 never produces DATA, 2 never returns NULL, 3 illegal rails
  int mode = 0;

  ncl_mult3_arbiter #(.NREQ(NREQ), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready),
    .mul_a_r1(mul_a_r1), .mul_a_r0(mul_a_r0), .mul_b_r1(mul_b_r1), .mul_b_r0(mul_b_r0),
    .mul_ki(mul_ki), .mul_p_r1(mul_p_r1), .mul_p_r0(mul_p_r0), .mul_ko(mul_ko),
    .err_timeout(err_timeout), .err_illegal(err_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Behavioural NCL multiplier with a random per-phase delay
  initial begin
    int   m_cnt, m_dly;
    bit   m_have;
    logic [5:0] prod;
    mul_p_r1 = 6'd0; mul_p_r0 = 6'd0; mul_ko = 1'b1;
    m_cnt = 0; m_dly = 0; m_have = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        mul_p_r1 = 6'd0; mul_p_r0 = 6'd0; mul_ko = 1'b1; m_have = 1'b0; m_cnt = 0;
      end else if (!m_have) begin
        if (mode != 1 && mul_ki === 1'b1 && (&(mul_a_r1 ^ mul_a_r0)) && (&(mul_b_r1 ^ mul_b_r0))) begin
          if (m_cnt >= m_dly) begin
            prod = {3'd0, mul_a_r1} * {3'd0, mul_b_r1};
            mul_p_r1 = (mode == 3) ? (prod | 6'd1) : prod;
            mul_p_r0 = (mode == 3) ? (~prod | 6'd1) : ~prod;
            mul_ko = 1'b0; m_have = 1'b1; m_cnt = 0; m_dly = $urandom_range(0, 3);
          end else m_cnt++;
        end else m_cnt = 0;
      end else begin
        if (mode != 2 && mul_ki === 1'b0 && ((mul_a_r1 | mul_a_r0 | mul_b_r1 | mul_b_r0) == 3'd0)) begin
          if (m_cnt >= m_dly) begin
            mul_p_r1 = 6'd0; mul_p_r0 = 6'd0;
            mul_ko = 1'b1; m_have = 1'b0; m_cnt = 0; m_dly = $urandom_range(0, 3);
          end else m_cnt++;
        end else m_cnt = 0;
      end
    end
  end

  // What the DUT saw at each active edge
  logic [NREQ-1:0]   s_valid;
  logic [3*NREQ-1:0] s_a, s_b;
  logic              s_rst, s_rspv;
  always @(posedge clk) begin
    s_valid <= req_valid;
    s_a     <= req_a;
    s_b     <= req_b;
    s_rst   <= rst;
    s_rspv  <= rsp_valid;
  end

  // Reference model: round-robin pointer, expected-response queue, grant log
  int m_ptr = 0;
  int exp_id_q[$];
  int exp_p_q[$];
  int g_log[$];
  initial begin
    bit   prev_grant;
    logic prev_ki;
    int   w;
    prev_grant = 1'b0;
    prev_ki = 1'b1;
    forever begin
      @(negedge clk);
      if (s_rst !== 1'b0) begin
        m_ptr = 0; exp_id_q.delete(); exp_p_q.delete(); prev_grant = 1'b0;
      end else begin
        if (req_ready !== {NREQ{1'b0}}) begin
          w = rr_pick(s_valid, m_ptr);
          if (w < 0) begin
            check_value("grant_spurious", 32'(req_ready), 32'd0);
          end else begin
            check_value("grant_winner", 32'(req_ready), 32'(1 << w));
            check_value("grant_single_cycle", 32'(prev_grant), 32'd0);
            check_value("grant_while_rsp_valid", 32'(s_rspv), 32'd0);
            m_ptr = (w + 1) % NREQ;
            g_log.push_back(w);
            if (mode == 0 || mode == 2) begin
              exp_id_q.push_back(w);
              exp_p_q.push_back(int'(s_a[3*w +: 3]) * int'(s_b[3*w +: 3]));
            end
          end
        end
        prev_grant = (req_ready !== {NREQ{1'b0}});
        if (rsp_valid === 1'b1) begin
          if (exp_id_q.size() == 0) begin
            check_value("rsp_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            check_value("rsp_id", 32'(rsp_id), 32'(exp_id_q[0]));
            check_value("rsp_p", 32'(rsp_p), 32'(exp_p_q[0]));
            if (rsp_ready === 1'b1) begin
              void'(exp_id_q.pop_front());
              void'(exp_p_q.pop_front());
            end
          end
        end
        if (mul_ki === 1'b1 && prev_ki === 1'b0) begin
          check_value("ki_after_null", 32'(mul_p_r1 | mul_p_r0), 32'd0);
        end
      end
      prev_ki = mul_ki;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic request(input int idx, input logic [2:0] a, input logic [2:0] b);
    req_a[3*idx +: 3] = a;
    req_b[3*idx +: 3] = b;
    req_valid[idx] = 1'b1;
  endtask

  task automatic wait_grant(input int idx, input string tag);
    int n = 0;
    while (req_ready[idx] !== 1'b1 && n < 100) begin tick(1); n++; end
    check_value(tag, 32'(req_ready[idx] === 1'b1), 32'd1);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin tick(1); n++; end
    check_value(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || rsp_valid !== 1'b0) && n < 300) begin tick(1); n++; end
    check_value(tag, 32'(busy | rsp_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick(2);
    check_value("rst_rails", 32'({mul_a_r1, mul_a_r0, mul_b_r1, mul_b_r0}), 32'd0);
    check_value("rst_ki", 32'(mul_ki), 32'd1);
    check_value("rst_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_p}), 32'd0);
    check_value("rst_flags", 32'({err_timeout, err_illegal, busy}), 32'd0);
    rst = 1'b0;
    tick(1);

    // 7*7 from requester 0
    request(0, 3'd7, 3'd7);
    wait_grant(0, "grant0");
    check_value("a_rails_77", 32'({mul_a_r1, mul_a_r0}), 32'b111000);
    check_value("b_rails_77", 32'({mul_b_r1, mul_b_r0}), 32'b111000);
    check_value("data_ki", 32'(mul_ki), 32'd1);
    check_value("data_busy", 32'(busy), 32'd1);
    wait_rsp("rsp0_arrives");
    check_value("rsp_p_49", 32'(rsp_p), 32'd49);
    check_value("rsp_id_0", 32'(rsp_id), 32'd0);
    check_value("nullw_ki", 32'(mul_ki), 32'd0);
    rsp_ready = 1'b1;
    wait_idle("idle_after_49");

    // 0*5 from requester 2
    request(2, 3'd0, 3'd5);
    wait_grant(2, "grant2");
    check_value("a_rails_0", 32'({mul_a_r1, mul_a_r0}), 32'b000111);
    check_value("b_rails_5", 32'({mul_b_r1, mul_b_r0}), 32'b101010);
    wait_rsp("rsp2_arrives");
    check_value("rsp_p_0", 32'(rsp_p), 32'd0);
    wait_idle("idle_after_0");

    // all four held: strict round robin from a fresh pointer
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) request(i, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    g_log.delete();
    n = 0;
    while (g_log.size() < 5 && n < 400) begin tick(1); n++; end
    req_valid = '0;
    check_value("rr_count", 32'(g_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < g_log.size(); k++) check_value("rr_order", 32'(g_log[k]), 32'(k % NREQ));
    wait_idle("idle_after_rr");

    // consumer stalls: no second grant while the result is held
    do_reset();
    request(0, 3'd6, 3'd5);
    wait_grant(0, "hold_grant0");
    wait_rsp("hold_rsp");
    request(1, 3'd3, 3'd3);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check_value("hold_no_grant", 32'(req_ready), 32'd0);
      check_value("hold_rsp_p", 32'(rsp_p), 32'd30);
    end
    rsp_ready = 1'b1;
    wait_grant(1, "hold_grant1");
    wait_idle("idle_after_hold");

    // multiplier never answers: DATA timeout
    do_reset();
    mode = 1;
    request(3, 3'd5, 3'd5);
    wait_grant(3, "to_grant");
    n = 0;
    while (err_timeout !== 1'b1 && n < TIMEOUT + 20) begin tick(1); n++; end
    check_value("timeout_flag", 32'(err_timeout), 32'd1);
    check_value("timeout_cycles", 32'(n), 32'(TIMEOUT));
    check_value("timeout_ki", 32'(mul_ki), 32'd0);
    check_value("timeout_busy", 32'(busy), 32'd1);
    check_value("timeout_no_rsp", 32'(rsp_valid), 32'd0);
    wait_idle("idle_after_timeout");

    // reset in the middle of DATA
    request(1, 3'd2, 3'd2);
    wait_grant(1, "mid_grant");
    tick(2);
    rst = 1'b1;
    tick(1);
    check_value("mid_rst_rails", 32'({mul_a_r1, mul_a_r0, mul_b_r1, mul_b_r0}), 32'd0);
    check_value("mid_rst_ki", 32'(mul_ki), 32'd1);
    check_value("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    check_value("mid_rst_errs", 32'({err_timeout, err_illegal}), 32'd0);
    rst = 1'b0;
    mode = 0;
    rsp_ready = 1'b0;
    tick(1);
    request(2, 3'd3, 3'd2);
    wait_grant(2, "fresh_grant");
    wait_rsp("fresh_rsp");
    check_value("fresh_p_6", 32'(rsp_p), 32'd6);
    check_value("fresh_id_2", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b1;
    wait_idle("idle_after_fresh");

    // both rails high on a product bit
    mode = 3;
    request(0, 3'd6, 3'd3);
    wait_grant(0, "ill_grant");
    n = 0;
    while (err_illegal !== 1'b1 && n < 30) begin tick(1); n++; end
    check_value("illegal_flag", 32'(err_illegal), 32'd1);
    check_value("illegal_no_rsp", 32'(rsp_valid), 32'd0);
    check_value("illegal_ki", 32'(mul_ki), 32'd0);
    wait_idle("idle_after_illegal");
    mode = 0;

    // multiplier stuck in DATA: NULL timeout halts until reset
    do_reset();
    mode = 2;
    rsp_ready = 1'b1;
    request(1, 3'd4, 3'd5);
    wait_grant(1, "stuck_grant");
    n = 0;
    while (err_timeout !== 1'b1 && n < 3 * TIMEOUT) begin tick(1); n++; end
    check_value("halt_flag", 32'(err_timeout), 32'd1);
    request(0, 3'd1, 3'd1);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check_value("halt_no_grant", 32'(req_ready), 32'd0);
    end
    check_value("halt_ki", 32'(mul_ki), 32'd0);
    check_value("halt_busy", 32'(busy), 32'd1);
    mode = 0;
    do_reset();

    // random traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      tick(1);
      rsp_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) request(i, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("idle_after_random");
    tick(2);
    check_value("random_drained", 32'(exp_id_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
